// File: rtl/mem_access.sv
// mem_access: byte-serial load/store stage. Loads and stores of 1, 2 or 4
// bytes are broken into single-byte req/ack transfers to a memory controller
// while the pipeline is stalled. Non-memory ops pass through combinationally.
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses and report them on misalign_o.

`ifndef AluOpBus
`define AluOpBus 7:0
`endif

package mem_access_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h20;
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    // last_idx is the index of the final byte (N-1): 0, 1 or 3
    typedef struct packed {
        logic       is_mem;
        logic       is_store;
        logic       sign_ext;
        logic [1:0] last_idx;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [7:0] op);
        op_info_t info;
        info = '0;
        case (op)
            OP_LB:  begin info.is_mem = 1'b1; info.sign_ext = 1'b1; info.last_idx = 2'd0; end
            OP_LBU: begin info.is_mem = 1'b1;                       info.last_idx = 2'd0; end
            OP_LH:  begin info.is_mem = 1'b1; info.sign_ext = 1'b1; info.last_idx = 2'd1; end
            OP_LHU: begin info.is_mem = 1'b1;                       info.last_idx = 2'd1; end
            OP_LW:  begin info.is_mem = 1'b1;                       info.last_idx = 2'd3; end
            OP_SB:  begin info.is_mem = 1'b1; info.is_store = 1'b1; info.last_idx = 2'd0; end
            OP_SH:  begin info.is_mem = 1'b1; info.is_store = 1'b1; info.last_idx = 2'd1; end
            OP_SW:  begin info.is_mem = 1'b1; info.is_store = 1'b1; info.last_idx = 2'd3; end
            default: info = '0;
        endcase
        return info;
    endfunction

endpackage

module mem_access
    import mem_access_pkg::*;
(
    input  logic             dclk,
    input  logic             rst,
    input  logic [`AluOpBus] aluop_MEM_i,
    input  logic             wreg_MEM_i,
    input  logic [4:0]       waddr_MEM_i,
    input  logic [31:0]      alurslt_MEM_i,
    input  logic [31:0]      storedata_MEM_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [7:0]       mem_wdata_o,
    input  logic [7:0]       mem_rdata_i,
    input  logic             mem_ack_i,
    output logic             stallreq_MEM_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic             misalign_o,
`endif
    output logic             wreg_WB_o,
    output logic [4:0]       waddr_WB_o,
    output logic [31:0]      wdata_WB_o
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sdata_q, sdata_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  waddr_q, waddr_d;
    logic        store_q, store_d;
    logic        sign_q, sign_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  k_q, k_d;
    logic        gap_q, gap_d;   // forces mem_req_o low for the cycle after an ack
    op_info_t    cur_op;

    assign cur_op = decode_op(aluop_MEM_i);

`ifdef MEM_MISALIGN_CHECK_EN
    logic misal_q, misal_d;
    logic misal_now;
    assign misal_now = (cur_op.last_idx == 2'd1 && alurslt_MEM_i[0]) ||
                       (cur_op.last_idx == 2'd3 && alurslt_MEM_i[1:0] != 2'b00);
`endif

    // State register with synchronous reset.
    always_ff @(posedge dclk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            sdata_q  <= '0;
            result_q <= '0;
            waddr_q  <= '0;
            store_q  <= 1'b0;
            sign_q   <= 1'b0;
            last_q   <= '0;
            k_q      <= '0;
            gap_q    <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
            misal_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            sdata_q  <= sdata_d;
            result_q <= result_d;
            waddr_q  <= waddr_d;
            store_q  <= store_d;
            sign_q   <= sign_d;
            last_q   <= last_d;
            k_q      <= k_d;
            gap_q    <= gap_d;
`ifdef MEM_MISALIGN_CHECK_EN
            misal_q  <= misal_d;
`endif
        end
    end

    // Next-state logic and all outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d        = state_q;
        addr_d         = addr_q;
        sdata_d        = sdata_q;
        result_d       = result_q;
        waddr_d        = waddr_q;
        store_d        = store_q;
        sign_d         = sign_q;
        last_d         = last_q;
        k_d            = k_q;
        gap_d          = gap_q;
        mem_req_o      = 1'b0;
        mem_we_o       = 1'b0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        stallreq_MEM_o = 1'b0;
        wreg_WB_o      = 1'b0;
        waddr_WB_o     = '0;
        wdata_WB_o     = '0;
`ifdef MEM_MISALIGN_CHECK_EN
        misal_d        = misal_q;
        misalign_o     = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (cur_op.is_mem) begin
                    stallreq_MEM_o = 1'b1;
                    addr_d         = alurslt_MEM_i;
                    sdata_d        = storedata_MEM_i;
                    waddr_d        = waddr_MEM_i;
                    store_d        = cur_op.is_store;
                    sign_d         = cur_op.sign_ext;
                    last_d         = cur_op.last_idx;
                    k_d            = '0;
                    gap_d          = 1'b0;
                    result_d       = '0;
                    state_d        = XFER;
`ifdef MEM_MISALIGN_CHECK_EN
                    misal_d = misal_now;
                    if (misal_now) state_d = DONE;
`endif
                end else begin
                    wreg_WB_o  = wreg_MEM_i;
                    waddr_WB_o = waddr_MEM_i;
                    wdata_WB_o = alurslt_MEM_i;
                end
            end

            XFER: begin
                stallreq_MEM_o = 1'b1;
                mem_we_o       = store_q;
                mem_addr_o     = addr_q + {30'd0, k_q};
                mem_wdata_o    = sdata_q[{k_q, 3'b000} +: 8];
                if (gap_q) begin
                    gap_d = 1'b0;
                end else begin
                    mem_req_o = 1'b1;
                    if (mem_ack_i) begin
                        if (!store_q) result_d[{k_q, 3'b000} +: 8] = mem_rdata_i;
                        if (k_q == last_q) begin
                            state_d = DONE;
                        end else begin
                            k_d   = k_q + 2'd1;
                            gap_d = 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                if (!store_q) begin
                    wreg_WB_o  = wreg_MEM_i;
                    waddr_WB_o = waddr_q;
                    case (last_q)
                        2'd0:    wdata_WB_o = sign_q ? {{24{result_q[7]}}, result_q[7:0]}
                                                     : {24'd0, result_q[7:0]};
                        2'd1:    wdata_WB_o = sign_q ? {{16{result_q[15]}}, result_q[15:0]}
                                                     : {16'd0, result_q[15:0]};
                        default: wdata_WB_o = result_q;
                    endcase
                end
`ifdef MEM_MISALIGN_CHECK_EN
                if (misal_q) begin
                    misalign_o = 1'b1;
                    wreg_WB_o  = 1'b0;
                    waddr_WB_o = '0;
                    wdata_WB_o = '0;
                end
`endif
            end

            default: state_d = IDLE;
        endcase

        // Reset holds every output quiet, including the IDLE pass-through.
        if (rst) begin
            mem_req_o      = 1'b0;
            mem_we_o       = 1'b0;
            mem_addr_o     = '0;
            mem_wdata_o    = '0;
            stallreq_MEM_o = 1'b0;
            wreg_WB_o      = 1'b0;
            waddr_WB_o     = '0;
            wdata_WB_o     = '0;
`ifdef MEM_MISALIGN_CHECK_EN
            misalign_o     = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed, table-driven bench for mem_access with a small byte-memory responder.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        dclk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_MEM_i;
    logic        wreg_MEM_i;
    logic [4:0]  waddr_MEM_i;
    logic [31:0] alurslt_MEM_i;
    logic [31:0] storedata_MEM_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_ack_i;
    logic        stallreq_MEM_o;
    logic        wreg_WB_o;
    logic [4:0]  waddr_WB_o;
    logic [31:0] wdata_WB_o;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int total = 0;
    int bad   = 0;

    mem_access dut (
        .dclk            (dclk),
        .rst             (rst),
        .aluop_MEM_i     (aluop_MEM_i),
        .wreg_MEM_i      (wreg_MEM_i),
        .waddr_MEM_i     (waddr_MEM_i),
        .alurslt_MEM_i   (alurslt_MEM_i),
        .storedata_MEM_i (storedata_MEM_i),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_rdata_i     (mem_rdata_i),
        .mem_ack_i       (mem_ack_i),
        .stallreq_MEM_o  (stallreq_MEM_o),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_o      (misalign_o),
`endif
        .wreg_WB_o       (wreg_WB_o),
        .waddr_WB_o      (waddr_WB_o),
        .wdata_WB_o      (wdata_WB_o)
    );

    always #5 dclk = ~dclk;

    // One vector: op inputs, memory contents (little-endian word), ack latency
    // in cycles of asserted req before ack, and the expected DONE results.
    typedef struct packed {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic        wreg;
        logic [4:0]  waddr;
        logic [31:0] mem;
        int          lat;
        logic        is_mem;
        logic        is_store;
        int          nbytes;
        logic        exp_wreg;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr,
                                input logic [31:0] sdata, input logic wreg,
                                input logic [4:0] waddr, input logic [31:0] mem,
                                input int lat, input logic is_mem, input logic is_store,
                                input int nbytes, input logic exp_wreg,
                                input logic [4:0] exp_waddr, input logic [31:0] exp_wdata,
                                input logic exp_mis);
        vec_t v;
        v.op = op; v.addr = addr; v.sdata = sdata; v.wreg = wreg; v.waddr = waddr;
        v.mem = mem; v.lat = lat; v.is_mem = is_mem; v.is_store = is_store;
        v.nbytes = nbytes; v.exp_wreg = exp_wreg; v.exp_waddr = exp_waddr;
        v.exp_wdata = exp_wdata; v.exp_mis = exp_mis;
        return v;
    endfunction

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return w[8*i +: 8];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          nb;
        int          req_cnt;
        int          cyc;
        bit          done;
        bit          prev_ack;
        logic [31:0] exp_addr;
        @(negedge dclk);
        mem_ack_i       = 1'b0;
        aluop_MEM_i     = v.op;
        alurslt_MEM_i   = v.addr;
        storedata_MEM_i = v.sdata;
        wreg_MEM_i      = v.wreg;
        waddr_MEM_i     = v.waddr;
        #1;
        if (!v.is_mem) begin
            check($sformatf("v%0d_pass_wdata", idx), wdata_WB_o, v.exp_wdata);
            check($sformatf("v%0d_pass_waddr", idx), waddr_WB_o, v.exp_waddr);
            check($sformatf("v%0d_pass_wreg", idx), wreg_WB_o, v.exp_wreg);
            check($sformatf("v%0d_pass_stall", idx), stallreq_MEM_o, 0);
            check($sformatf("v%0d_pass_req", idx), mem_req_o, 0);
            return;
        end
        check($sformatf("v%0d_idle_stall", idx), stallreq_MEM_o, 1);
        check($sformatf("v%0d_idle_req", idx), mem_req_o, 0);
        nb = 0; req_cnt = 0; cyc = 0; done = 0; prev_ack = 0;
        while (!done && cyc < 200) begin
            @(negedge dclk);
            mem_ack_i = 1'b0;
            #1;
            cyc++;
            if (prev_ack) check($sformatf("v%0d_req_gap", idx), mem_req_o, 0);
            if (!stallreq_MEM_o) begin
                done = 1;
                check($sformatf("v%0d_nbytes", idx), nb, v.nbytes);
                check($sformatf("v%0d_done_req", idx), mem_req_o, 0);
                check($sformatf("v%0d_done_wreg", idx), wreg_WB_o, v.exp_wreg);
                if (!v.exp_mis) begin
                    check($sformatf("v%0d_done_waddr", idx), waddr_WB_o, v.exp_waddr);
                    check($sformatf("v%0d_done_wdata", idx), wdata_WB_o, v.exp_wdata);
                end
`ifdef MEM_MISALIGN_CHECK_EN
                check($sformatf("v%0d_misalign", idx), misalign_o, v.exp_mis);
`endif
            end else if (mem_req_o) begin
                exp_addr = v.addr + 32'(nb);
                check($sformatf("v%0d_addr_b%0d", idx, nb), mem_addr_o, exp_addr);
                check($sformatf("v%0d_we_b%0d", idx, nb), mem_we_o, v.is_store);
                if (v.is_store)
                    check($sformatf("v%0d_wbyte_b%0d", idx, nb), mem_wdata_o, byte_of(v.sdata, nb));
                if (req_cnt >= v.lat) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = byte_of(v.mem, nb);
                    nb++;
                    req_cnt  = 0;
                    prev_ack = 1;
                end else begin
                    req_cnt++;
                    prev_ack = 0;
                end
            end else begin
                prev_ack = 0;
            end
        end
        check($sformatf("v%0d_timeout", idx), done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        int req_cnt;
        int cyc;

        // Vector table
        vecs.push_back(mk(OP_ADD, 32'h12345678, 32'h0, 1'b1, 5'd5,  32'h0, 0, 1'b0, 1'b0, 0, 1'b1, 5'd5,  32'h12345678, 1'b0));
        vecs.push_back(mk(OP_LW,  32'h00000100, 32'h0, 1'b1, 5'd7,  32'h12345678, 1, 1'b1, 1'b0, 4, 1'b1, 5'd7, 32'h12345678, 1'b0));
        vecs.push_back(mk(OP_LB,  32'h00000007, 32'h0, 1'b1, 5'd3,  32'h00000080, 1, 1'b1, 1'b0, 1, 1'b1, 5'd3, 32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(OP_LBU, 32'h00000007, 32'h0, 1'b1, 5'd3,  32'h00000080, 1, 1'b1, 1'b0, 1, 1'b1, 5'd3, 32'h00000080, 1'b0));
        vecs.push_back(mk(OP_SH,  32'h00000020, 32'hAABBCCDD, 1'b1, 5'd9, 32'h0, 1, 1'b1, 1'b1, 2, 1'b0, 5'd0, 32'h0, 1'b0));
        vecs.push_back(mk(OP_LH,  32'h00000030, 32'h0, 1'b1, 5'd10, 32'h00008001, 0, 1'b1, 1'b0, 2, 1'b1, 5'd10, 32'hFFFF8001, 1'b0));
        vecs.push_back(mk(OP_LHU, 32'h00000030, 32'h0, 1'b1, 5'd11, 32'h00008001, 2, 1'b1, 1'b0, 2, 1'b1, 5'd11, 32'h00008001, 1'b0));
        vecs.push_back(mk(OP_SB,  32'h00000055, 32'h000000EE, 1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 1, 1'b0, 5'd0, 32'h0, 1'b0));
        vecs.push_back(mk(OP_SW,  32'h00000200, 32'h11223344, 1'b1, 5'd4, 32'h0, 3, 1'b1, 1'b1, 4, 1'b0, 5'd0, 32'h0, 1'b0));
        vecs.push_back(mk(OP_ADD, 32'hDEADBEEF, 32'h0, 1'b0, 5'd31, 32'h0, 0, 1'b0, 1'b0, 0, 1'b0, 5'd31, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(OP_LB,  32'h00000009, 32'h0, 1'b1, 5'd12, 32'h0000007F, 0, 1'b1, 1'b0, 1, 1'b1, 5'd12, 32'h0000007F, 1'b0));
`ifdef MEM_MISALIGN_CHECK_EN
        vecs.push_back(mk(OP_LW,  32'h00000102, 32'h0, 1'b1, 5'd13, 32'h0, 0, 1'b1, 1'b0, 0, 1'b0, 5'd0, 32'h0, 1'b1));
        vecs.push_back(mk(OP_SH,  32'h00000021, 32'h5566, 1'b0, 5'd0, 32'h0, 0, 1'b1, 1'b1, 0, 1'b0, 5'd0, 32'h0, 1'b1));
`else
        vecs.push_back(mk(OP_LW,  32'hFFFFFFFE, 32'h0, 1'b1, 5'd13, 32'hA1B2C3D4, 0, 1'b1, 1'b0, 4, 1'b1, 5'd13, 32'hA1B2C3D4, 1'b0));
        vecs.push_back(mk(OP_LH,  32'h00000031, 32'h0, 1'b1, 5'd14, 32'h00001234, 1, 1'b1, 1'b0, 2, 1'b1, 5'd14, 32'h00001234, 1'b0));
`endif

        // Reset state: outputs quiet even with a pass-through op on the inputs
        rst             = 1'b1;
        aluop_MEM_i     = OP_ADD;
        alurslt_MEM_i   = 32'h12345678;
        storedata_MEM_i = 32'h0;
        wreg_MEM_i      = 1'b1;
        waddr_MEM_i     = 5'd5;
        mem_rdata_i     = 8'h0;
        mem_ack_i       = 1'b0;
        repeat (2) @(negedge dclk);
        #1;
        check("rst_req", mem_req_o, 0);
        check("rst_we", mem_we_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wbyte", mem_wdata_o, 0);
        check("rst_stall", stallreq_MEM_o, 0);
        check("rst_wreg", wreg_WB_o, 0);
        check("rst_waddr", waddr_WB_o, 0);
        check("rst_wdata", wdata_WB_o, 0);
        @(negedge dclk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset in the middle of a word store after two bytes were acked
        @(negedge dclk);
        aluop_MEM_i     = OP_SW;
        alurslt_MEM_i   = 32'h00000040;
        storedata_MEM_i = 32'h99887766;
        wreg_MEM_i      = 1'b0;
        waddr_MEM_i     = 5'd0;
        mem_ack_i       = 1'b0;
        acks = 0; req_cnt = 0; cyc = 0;
        while (acks < 2 && cyc < 50) begin
            @(negedge dclk);
            mem_ack_i = 1'b0;
            #1;
            cyc++;
            if (mem_req_o) begin
                if (req_cnt >= 1) begin
                    check($sformatf("abort_addr_b%0d", acks), mem_addr_o, 32'h40 + 32'(acks));
                    check($sformatf("abort_wbyte_b%0d", acks), mem_wdata_o, byte_of(storedata_MEM_i, acks));
                    mem_ack_i = 1'b1;
                    acks++;
                    req_cnt = 0;
                end else begin
                    req_cnt++;
                end
            end
        end
        check("abort_acks", acks, 2);
        @(negedge dclk);
        mem_ack_i = 1'b0;
        rst       = 1'b1;
        #1;
        check("abort_rst_req", mem_req_o, 0);
        check("abort_rst_stall", stallreq_MEM_o, 0);
        @(negedge dclk);
        rst           = 1'b0;
        aluop_MEM_i   = OP_NOP;
        alurslt_MEM_i = 32'h0000ABCD;
        wreg_MEM_i    = 1'b1;
        waddr_MEM_i   = 5'd2;
        mem_ack_i     = 1'b1;
        #1;
        check("abort_idle_req", mem_req_o, 0);
        check("abort_idle_stall", stallreq_MEM_o, 0);
        check("abort_idle_wdata", wdata_WB_o, 32'h0000ABCD);
        @(negedge dclk);
        #1;
        check("late_ack_req", mem_req_o, 0);
        check("late_ack_stall", stallreq_MEM_o, 0);
        mem_ack_i = 1'b0;
        // A fresh load afterwards starts at byte 0 of its own address
        run_vec(mk(OP_LB, 32'h00000007, 32'h0, 1'b1, 5'd6, 32'h00000080, 1,
                   1'b1, 1'b0, 1, 1'b1, 5'd6, 32'hFFFFFF80, 1'b0), 99);

        repeat (2) @(negedge dclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
